// File: rtl/uart_periph_pkg.sv
// Shared definitions for the UART peripheral: register offsets, status bit
// positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIVL   = 2'd2;
    localparam logic [1:0] OFF_DIVH   = 2'd3;

    localparam int unsigned ST_RX_VALID = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_BUSY  = 3;
    localparam int unsigned ST_OVERRUN  = 4;
    localparam int unsigned ST_FERR     = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_periph_if.sv
// CPU I/O bus as seen by the UART: decoder chip-select, Z80 strobes,
// port offset and the two data directions.
interface uart_periph_if;

    logic       cs_i;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] addr_i;
    logic [7:0] data_i;
    logic [7:0] data_o;

    modport master (output cs_i, wr_n, rd_n, addr_i, data_i, input data_o);
    modport slave  (input cs_i, wr_n, rd_n, addr_i, data_i, output data_o);

endinterface

// File: rtl/uart_periph_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. A pop on an empty FIFO is
// dropped; a push on a full FIFO succeeds only if a pop happens that clock.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rptr_q[AW-1:0]];

    // Pointer update; the wrap bit distinguishes full from empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_periph.sv
// I/O-mapped UART at ports 0x70-0x73: TX FIFO, RX holding register,
// status and a 16-bit baud divisor (clocks per bit minus 1).
// Define UART_IRQ_EN to add the ien register and the irq_n_o output.
module uart_periph
    import uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH    = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd233
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    uart_periph_if.slave bus,
    output logic         uart_tx_o,
`ifdef UART_IRQ_EN
    output logic         irq_n_o,
`endif
    input  logic         uart_rx_i
);

    logic        wr_act, rd_act, wr_q, rd_q, wr_pulse, rd_end;
    logic [1:0]  rd_addr_q;
    logic        rd_data_end, rd_stat_end;
    logic [15:0] div_q;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;
    logic        rx_meta, rx_s, rx_prev;
    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick, rx_store;
    logic [7:0]  rx_hold_q;
    logic        rx_valid_q, overrun_q, ferr_q;
    logic [7:0]  status;

    assign wr_act      = bus.cs_i && !bus.wr_n;
    assign rd_act      = bus.cs_i && !bus.rd_n;
    assign wr_pulse    = wr_act && !wr_q;
    assign rd_end      = rd_q && !rd_act;
    // The address may be gone when the strobe releases, so use the one latched during the access.
    assign rd_data_end = rd_end && (rd_addr_q == OFF_DATA);
    assign rd_stat_end = rd_end && (rd_addr_q == OFF_STATUS);

    // Strobe history for once-per-access write and read-end detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            wr_q <= wr_act;
            rd_q <= rd_act;
            if (rd_act) rd_addr_q <= bus.addr_i;
        end
    end

    // Baud divisor bytes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= DEFAULT_DIV;
        end else if (wr_pulse) begin
            if (bus.addr_i == OFF_DIVL) div_q[7:0]  <= bus.data_i;
            if (bus.addr_i == OFF_DIVH) div_q[15:8] <= bus.data_i;
        end
    end

    assign fifo_push = wr_pulse && (bus.addr_i == OFF_DATA);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (bus.data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_tick = (tx_cnt == '0);

    // TX next state; STOP chains straight into START when more data is queued.
    always_comb begin
        tx_next  = tx_state;
        fifo_pop = 1'b0;
        case (tx_state)
            TX_IDLE:  if (!fifo_empty) begin tx_next = TX_START; fifo_pop = 1'b1; end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                          if (!fifo_empty) begin tx_next = TX_START; fifo_pop = 1'b1; end
                          else tx_next = TX_IDLE;
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX state, bit timer and shifter; divisor reloads at each bit boundary.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (fifo_pop) begin
                tx_shift <= fifo_rdata;
                tx_cnt   <= div_q;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= div_q;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // Combinational from reset flops so a reset forces the line idle without a clock.
    assign uart_tx_o = (tx_state == TX_START) ? 1'b0 :
                       (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // Two-flop synchroniser plus one history flop for start-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_tick = (rx_cnt == '0);

    // RX next state; a start bit that is high at its midpoint is a glitch.
    always_comb begin
        rx_next  = rx_state;
        rx_store = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) begin rx_next = RX_IDLE; rx_store = 1'b1; end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX state and sampler; idle keeps the half-bit count preloaded for the next start edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= {1'b0, div_q[15:1]};
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_cnt <= div_q;
                if (rx_state == RX_DATA) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    // Holding register and flags; a store overrides a read-end clear on the same clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (rd_data_end) rx_valid_q <= 1'b0;
            if (rd_stat_end) begin
                overrun_q <= 1'b0;
                ferr_q    <= 1'b0;
            end
            if (rx_store) begin
                rx_hold_q  <= rx_shift;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rd_data_end) overrun_q <= 1'b1;
                if (!rx_s) ferr_q <= 1'b1;
            end
        end
    end

    // Status register assembly.
    always_comb begin
        status              = '0;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_TX_FULL]  = fifo_full;
        status[ST_TX_EMPTY] = fifo_empty;
        status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
        status[ST_OVERRUN]  = overrun_q;
        status[ST_FERR]     = ferr_q;
    end

    // Read mux, zero outside a read.
    always_comb begin
        bus.data_o = '0;
        if (rd_act) begin
            case (bus.addr_i)
                OFF_DATA:   bus.data_o = rx_hold_q;
                OFF_STATUS: bus.data_o = status;
                OFF_DIVL:   bus.data_o = div_q[7:0];
                OFF_DIVH:   bus.data_o = div_q[15:8];
                default:    bus.data_o = '0;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic [2:0] ien_q;

    // Interrupt enables live at the status offset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ien_q <= '0;
        else if (wr_pulse && bus.addr_i == OFF_STATUS) ien_q <= bus.data_i[2:0];
    end

    assign irq_n_o = !((rx_valid_q & ien_q[0]) | (fifo_empty & ien_q[1]) |
                       ((overrun_q | ferr_q) & ien_q[2]));
`endif

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph: scoreboard queues for TX bytes (checked by
// a line monitor) and RX bytes (checked on data-register reads).
module tb_uart_periph;
    import uart_pkg::*;

    localparam int unsigned BIT_T = 40;   // divisor 3 -> 4 clocks of 10 time units

    logic clk_i     = 1'b0;
    logic rst_n_i   = 1'b0;
    logic uart_rx_i = 1'b1;
    logic uart_tx_o;
`ifdef UART_IRQ_EN
    logic irq_n_o;
`endif

    uart_periph_if bus ();

    uart_periph #(.TX_DEPTH(16), .DEFAULT_DIV(16'd233)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .bus       (bus),
        .uart_tx_o (uart_tx_o),
`ifdef UART_IRQ_EN
        .irq_n_o   (irq_n_o),
`endif
        .uart_rx_i (uart_rx_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    logic [7:0] tx_exp_q [$];
    logic [7:0] rx_exp_q [$];
    logic       tx_abort    = 1'b0;
    int unsigned mon_frames  = 0;
    int unsigned mon_gapless = 0;
    int unsigned last_start  = 0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic        m_ferr  = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int unsigned hold);
        @(negedge clk_i);
        bus.addr_i = a;
        bus.data_i = d;
        bus.cs_i   = 1'b1;
        bus.wr_n   = 1'b0;
        repeat (hold) @(negedge clk_i);
        bus.cs_i = 1'b0;
        bus.wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk_i);
        bus.addr_i = a;
        bus.cs_i   = 1'b1;
        bus.rd_n   = 1'b0;
        repeat (2) @(negedge clk_i);
        d = bus.data_o;
        bus.cs_i = 1'b0;
        bus.rd_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 16'(d), 16'(exp));
    endtask

    function automatic logic [7:0] model_status();
        return {2'b00, m_ferr, m_ovr, 1'b0, 1'b1, 1'b0, m_valid};
    endfunction

    task automatic read_status(input string tag);
        read_check(tag, OFF_STATUS, model_status());
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic read_rx_data(input string tag);
        logic [7:0] d;
        bus_read(OFF_DATA, d);
        check({tag, "_queued"}, 16'(rx_exp_q.size()), 16'd1);
        if (rx_exp_q.size() > 0) check(tag, 16'(d), 16'(rx_exp_q.pop_front()));
        m_valid = 1'b0;
    endtask

    // Drives one frame at a phase unrelated to the clock and updates the holding-register model.
    task automatic rx_send(input logic [7:0] b, input logic stop);
        if (m_valid) begin
            m_ovr = 1'b1;
            rx_exp_q.delete();
        end
        rx_exp_q.push_back(b);
        m_valid = 1'b1;
        if (!stop) m_ferr = 1'b1;
        #3;
        uart_rx_i = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            #(BIT_T);
        end
        uart_rx_i = stop;
        #(BIT_T);
        uart_rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic wait_tx_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (tx_exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 16'(tx_exp_q.size()), 16'd0);
        repeat (8) @(negedge clk_i);
    endtask

    // Line monitor: samples each bit mid-period at 4 clocks per bit.
    initial begin : tx_mon
        forever begin
            logic [7:0]  b;
            logic        start_ok;
            logic        stop_bit;
            int unsigned st;
            @(negedge uart_tx_o);
            st = cyc;
            repeat (2) @(negedge clk_i);
            start_ok = ~uart_tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk_i);
                b[i] = uart_tx_o;
            end
            repeat (4) @(negedge clk_i);
            stop_bit = uart_tx_o;
            if (!tx_abort) begin
                check("tx_start_bit", 16'(start_ok), 16'd1);
                check("tx_stop_bit", 16'(stop_bit), 16'd1);
                check("tx_frame_expected", 16'(tx_exp_q.size() > 0), 16'd1);
                if (tx_exp_q.size() > 0) check("tx_byte", 16'(b), 16'(tx_exp_q.pop_front()));
                if (mon_frames > 0 && st - last_start == 10 * 4) mon_gapless++;
                last_start = st;
                mon_frames++;
            end
        end
    end

    initial begin : watchdog
        #(600000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned g0;
        bus.cs_i   = 1'b0;
        bus.wr_n   = 1'b1;
        bus.rd_n   = 1'b1;
        bus.addr_i = '0;
        bus.data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Reset state
        check("reset_tx_idle", 16'(uart_tx_o), 16'd1);
        check("reset_data_o_zero", 16'(bus.data_o), 16'd0);
        read_status("reset_status");
        read_check("reset_divl", OFF_DIVL, 8'hE9);
        read_check("reset_divh", OFF_DIVH, 8'h00);
`ifdef UART_IRQ_EN
        check("reset_irq_n", 16'(irq_n_o), 16'd1);
`endif

        // Divisor 3 -> 4 clocks per bit
        bus_write(OFF_DIVL, 8'h03, 3);
        bus_write(OFF_DIVH, 8'h00, 3);
        read_check("divl_readback", OFF_DIVL, 8'h03);
        read_check("divh_readback", OFF_DIVH, 8'h00);

        // Single frame 0x55
        tx_exp_q.push_back(8'h55);
        bus_write(OFF_DATA, 8'h55, 3);
        read_check("status_tx_busy", OFF_STATUS, 8'h0C);
        wait_tx_idle("tx_55_drained", 200);
        read_check("status_tx_done", OFF_STATUS, 8'h04);

        // Burst: the shifter takes the first byte at once, so 17 bytes fill shifter + 16-deep FIFO
        // and the 18th is dropped.
        g0 = mon_gapless;
        for (int i = 0; i < 17; i++) tx_exp_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 18; i++) bus_write(OFF_DATA, 8'(8'h10 + i), 1);
        read_check("status_tx_full", OFF_STATUS, 8'h0A);
        wait_tx_idle("tx_burst_drained", 17 * 40 + 200);
        check("tx_burst_gapless", 16'(mon_gapless - g0), 16'd16);
        read_check("status_after_burst", OFF_STATUS, 8'h04);

        // RX single byte
        rx_send(8'hA3, 1'b1);
        read_status("rx_a3_status");
        read_rx_data("rx_a3_data");
        read_status("rx_a3_status_after");

        // RX overrun
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        read_status("rx_ovr_status");
        read_rx_data("rx_ovr_data");
        read_status("rx_ovr_status_after");

        // RX framing error
        rx_send(8'h7E, 1'b0);
        read_status("rx_ferr_status");
        read_rx_data("rx_ferr_data");
        read_status("rx_ferr_status_after");

        // One-clock glitch on idle line
        @(negedge clk_i);
        uart_rx_i = 1'b0;
        @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
        read_status("rx_glitch_status");

        // Status-offset write never alters the status value
        bus_write(OFF_STATUS, 8'hFF, 3);
        read_check("status_write_ignored", OFF_STATUS, 8'h04);

`ifdef UART_IRQ_EN
        bus_write(OFF_STATUS, 8'h01, 3);
        @(negedge clk_i);
        check("irq_idle_high", 16'(irq_n_o), 16'd1);
        rx_send(8'h5A, 1'b1);
        check("irq_low_after_rx", 16'(irq_n_o), 16'd0);
        read_rx_data("irq_rx_data");
        check("irq_high_after_read", 16'(irq_n_o), 16'd1);
`endif

        // Reset in the middle of a TX frame
        tx_abort = 1'b1;
        bus_write(OFF_DATA, 8'h00, 3);
        repeat (15) @(negedge clk_i);
        check("tx_mid_frame_low", 16'(uart_tx_o), 16'd0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("tx_async_reset", 16'(uart_tx_o), 16'd1);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        read_check("status_after_reset", OFF_STATUS, 8'h04);
        read_check("divl_after_reset", OFF_DIVL, 8'hE9);
        read_check("divh_after_reset", OFF_DIVH, 8'h00);
        repeat (60) @(negedge clk_i);
        check("tx_idle_after_reset", 16'(uart_tx_o), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
